// File: rtl/gb_pkg.sv
// Shared definitions for the ghostbus router: FSM encoding, region decode, timeout fill.
package gb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } gb_state_t;

    localparam logic [255:0] GB_TIMEOUT_DATA = '1;

    function automatic logic [31:0] region_of(
        input logic [63:0] addr,
        input int unsigned sub_aw
    );
        return 32'(addr >> sub_aw);
    endfunction

endpackage

// File: rtl/gb_local_regs.sv
// Local region of the ghostbus router: CSR bank, optional RAM window, registered read data.
module gb_local_regs
    import gb_pkg::*;
#(
    parameter int SUB_AW    = 10,
    parameter int DW        = 32,
    parameter int NREG      = 4,
    parameter int RAM_BASE  = 'h40,
    parameter int RAM_DEPTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [SUB_AW-1:0]  i_addr,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [DW-1:0]      i_wdata,
    output logic [DW-1:0]      o_rdata,
    output logic [NREG*DW-1:0] o_csr_q,
    output logic [NREG-1:0]    o_csr_wstb
);

    logic [DW-1:0]   r_csr [NREG];
    logic [NREG-1:0] r_csr_wstb;
    logic [DW-1:0]   r_rdata;
    logic            w_csr_hit;
    logic            w_ram_hit;
    logic [DW-1:0]   w_ram_rdata;
    logic [DW-1:0]   w_rdata;

    assign w_csr_hit = 32'(i_addr) < 32'(NREG);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csr_wstb <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_csr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_csr_wstb[i] <= i_we && (32'(i_addr) == 32'(i));
                if (i_we && (32'(i_addr) == 32'(i))) begin
                    r_csr[i] <= i_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_csr_q
        assign o_csr_q[g*DW +: DW] = r_csr[g];
    end

    if (RAM_DEPTH > 0) begin : g_ram
        localparam int RB  = $clog2(RAM_DEPTH);
        localparam int RIW = (RB > 0) ? RB : 1;

        logic [DW-1:0]  r_ram [RAM_DEPTH];
        logic [RIW-1:0] w_idx;

        if ((RAM_BASE % RAM_DEPTH) != 0) begin : g_align_chk
            $error("gb_local_regs: RAM_BASE not aligned to RAM_DEPTH");
        end

        assign w_idx       = RIW'(32'(i_addr) % 32'(RAM_DEPTH));
        assign w_ram_hit   = (32'(i_addr) >> RB) == (32'(RAM_BASE) >> RB);
        assign w_ram_rdata = r_ram[w_idx];

        // RAM contents deliberately survive reset
        always_ff @(posedge i_clk) begin
            if (i_we && w_ram_hit && !w_csr_hit) begin
                r_ram[w_idx] <= i_wdata;
            end
        end
    end else begin : g_no_ram
        assign w_ram_hit   = 1'b0;
        assign w_ram_rdata = '0;
    end

    always_comb begin
        w_rdata = '0;
        if (w_csr_hit) begin
            for (int i = 0; i < NREG; i++) begin
                if (32'(i_addr) == 32'(i)) begin
                    w_rdata = r_csr[i];
                end
            end
        end else if (w_ram_hit) begin
            w_rdata = w_ram_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rdata;
        end
    end

    assign o_rdata    = r_rdata;
    assign o_csr_wstb = r_csr_wstb;

endmodule

// File: rtl/gb_router.sv
// Ghostbus address decoder/router: local CSR/RAM region plus NCH handshaked channels.
// Optional read timeout enabled by defining GHOSTBUS_TIMEOUT_EN.
module gb_router
    import gb_pkg::*;
#(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int NCH       = 2,
    parameter int SUB_AW    = 10,
    parameter int NREG      = 4,
    parameter int RAM_BASE  = 'h40,
    parameter int RAM_DEPTH = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic               gb_clk,
    input  logic               gb_rst_n,
    input  logic [AW-1:0]      gb_addr,
    input  logic [DW-1:0]      gb_dout,
    input  logic               gb_we,
    input  logic               gb_re,
    output logic [DW-1:0]      gb_din,
    output logic               gb_rvalid,
    output logic               gb_busy,
    output logic               gb_err,
    output logic [NCH*AW-1:0]  sub_addr,
    output logic [DW-1:0]      sub_dout,
    output logic [NCH-1:0]     sub_we,
    output logic [NCH-1:0]     sub_re,
    input  logic [NCH*DW-1:0]  sub_din,
    input  logic [NCH-1:0]     sub_rvalid,
    output logic [NREG*DW-1:0] csr_q,
    output logic [NREG-1:0]    csr_wstb
);

    if (NCH < 1 || NCH > 15) begin : g_nch_chk
        $error("gb_router: NCH out of range");
    end
    if ((NCH + 1) > (1 << (AW - SUB_AW))) begin : g_map_chk
        $error("gb_router: not enough region bits for NCH");
    end
    if (TIMEOUT < 1) begin : g_tmo_chk
        $error("gb_router: TIMEOUT must be positive");
    end

    gb_state_t         r_state;
    gb_state_t         w_next;
    logic [31:0]       w_region;
    logic              w_local;
    logic              w_chan;
    logic              w_unmapped;
    logic              w_idle;
    logic              w_acc_we;
    logic              w_acc_re;
    logic [DW-1:0]     w_loc_rdata;
    logic              w_sel_rv;
    logic [DW-1:0]     w_sel_din;
    logic              w_tmo;

    logic [SUB_AW-1:0] r_rel_addr;
    logic [DW-1:0]     r_sub_dout;
    logic [NCH-1:0]    r_sub_we;
    logic [NCH-1:0]    r_sub_re;
    logic [3:0]        r_sel;
    logic [DW-1:0]     r_din;
    logic              r_sel_local;
    logic              r_rvalid;
    logic              r_err;

    assign w_region   = region_of(64'(gb_addr), SUB_AW);
    assign w_local    = w_region == 32'd0;
    assign w_chan     = (w_region >= 32'd1) && (w_region <= 32'(NCH));
    assign w_unmapped = !w_local && !w_chan;
    assign w_idle     = r_state == ST_IDLE;
    // Write wins over a simultaneous read; nothing is accepted while busy
    assign w_acc_we   = w_idle && gb_we;
    assign w_acc_re   = w_idle && gb_re && !gb_we;

    gb_local_regs #(
        .SUB_AW    (SUB_AW),
        .DW        (DW),
        .NREG      (NREG),
        .RAM_BASE  (RAM_BASE),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_local (
        .i_clk      (gb_clk),
        .i_rst_n    (gb_rst_n),
        .i_addr     (gb_addr[SUB_AW-1:0]),
        .i_we       (w_acc_we && w_local),
        .i_re       (w_acc_re && w_local),
        .i_wdata    (gb_dout),
        .o_rdata    (w_loc_rdata),
        .o_csr_q    (csr_q),
        .o_csr_wstb (csr_wstb)
    );

    always_comb begin
        w_sel_rv  = 1'b0;
        w_sel_din = '0;
        for (int k = 0; k < NCH; k++) begin
            if (32'(r_sel) == 32'(k)) begin
                w_sel_rv  = sub_rvalid[k];
                w_sel_din = sub_din[k*DW +: DW];
            end
        end
    end

`ifdef GHOSTBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_tcnt <= '0;
        end else if (w_idle) begin
            r_tcnt <= '0;
        end else if (!w_tmo) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    assign w_tmo = !w_idle && (r_tcnt == TW'(TIMEOUT));
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_acc_re && w_chan) w_next = ST_WAIT;
            ST_WAIT: if (w_sel_rv || w_tmo) w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_rel_addr  <= '0;
            r_sub_dout  <= '0;
            r_sub_we    <= '0;
            r_sub_re    <= '0;
            r_sel       <= '0;
            r_din       <= '0;
            r_sel_local <= 1'b0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_sub_we[k] <= w_acc_we && (w_region == 32'(k + 1));
                r_sub_re[k] <= w_acc_re && (w_region == 32'(k + 1));
            end
            if ((w_acc_we || w_acc_re) && w_chan) begin
                r_rel_addr <= gb_addr[SUB_AW-1:0];
            end
            if (w_acc_we && w_chan) begin
                r_sub_dout <= gb_dout;
            end
            if (w_acc_re && w_chan) begin
                r_sel <= 4'(w_region - 32'd1);
            end
            if (w_acc_re && w_local) begin
                r_rvalid    <= 1'b1;
                r_sel_local <= 1'b1;
            end
            if (w_acc_re && w_unmapped) begin
                r_rvalid    <= 1'b1;
                r_err       <= 1'b1;
                r_sel_local <= 1'b0;
                r_din       <= '0;
            end
            if (!w_idle) begin
                if (w_sel_rv) begin
                    r_rvalid    <= 1'b1;
                    r_sel_local <= 1'b0;
                    r_din       <= w_sel_din;
                end else if (w_tmo) begin
                    r_rvalid    <= 1'b1;
                    r_err       <= 1'b1;
                    r_sel_local <= 1'b0;
                    r_din       <= GB_TIMEOUT_DATA[DW-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_sub_addr
        assign sub_addr[g*AW +: AW] = AW'(r_rel_addr);
    end

    // Local read data stays in the local block and is held there
    assign gb_din    = r_sel_local ? w_loc_rdata : r_din;
    assign gb_rvalid = r_rvalid;
    assign gb_err    = r_err;
    assign gb_busy   = !w_idle;
    assign sub_dout  = r_sub_dout;
    assign sub_we    = r_sub_we;
    assign sub_re    = r_sub_re;

endmodule

// File: tb/tb_gb_router.sv
// Directed self-checking bench for gb_router (default build; timeout case with GHOSTBUS_TIMEOUT_EN).
module tb_gb_router;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int NCH  = 2;
    localparam int NREG = 4;

    logic              gb_clk = 1'b0;
    logic              gb_rst_n;
    logic [AW-1:0]     gb_addr;
    logic [DW-1:0]     gb_dout;
    logic              gb_we;
    logic              gb_re;
    logic [DW-1:0]     gb_din;
    logic              gb_rvalid;
    logic              gb_busy;
    logic              gb_err;
    logic [NCH*AW-1:0] sub_addr;
    logic [DW-1:0]     sub_dout;
    logic [NCH-1:0]    sub_we;
    logic [NCH-1:0]    sub_re;
    logic [NCH*DW-1:0] sub_din;
    logic [NCH-1:0]    sub_rvalid;
    logic [NREG*DW-1:0] csr_q;
    logic [NREG-1:0]   csr_wstb;

    int n_chk = 0;
    int n_err = 0;
    int busy_cnt;
    int wait_cnt;

    gb_router #(
        .AW(AW), .DW(DW), .NCH(NCH), .SUB_AW(10), .NREG(NREG),
        .RAM_BASE('h40), .RAM_DEPTH(8), .TIMEOUT(10)
    ) dut (
        .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .gb_addr(gb_addr),
        .gb_dout(gb_dout), .gb_we(gb_we), .gb_re(gb_re),
        .gb_din(gb_din), .gb_rvalid(gb_rvalid), .gb_busy(gb_busy),
        .gb_err(gb_err), .sub_addr(sub_addr), .sub_dout(sub_dout),
        .sub_we(sub_we), .sub_re(sub_re), .sub_din(sub_din),
        .sub_rvalid(sub_rvalid), .csr_q(csr_q), .csr_wstb(csr_wstb)
    );

    always #5 gb_clk = ~gb_clk;

    task automatic tick();
        @(posedge gb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        gb_rst_n   = 1'b0;
        gb_addr    = '0;
        gb_dout    = '0;
        gb_we      = 1'b0;
        gb_re      = 1'b0;
        sub_din    = '0;
        sub_rvalid = '0;
        repeat (2) tick();
        chk("rst_rvalid", 128'(gb_rvalid), 128'(0));
        chk("rst_busy", 128'(gb_busy), 128'(0));
        chk("rst_err", 128'(gb_err), 128'(0));
        chk("rst_din", 128'(gb_din), 128'(0));
        chk("rst_csr_q", 128'(csr_q), 128'(0));
        chk("rst_sub_strb", 128'({sub_we, sub_re, csr_wstb}), 128'(0));
        gb_rst_n = 1'b1;
        tick();

        // CSR write then read
        gb_addr = 24'h1; gb_dout = 32'hA5; gb_we = 1'b1;
        tick();
        gb_we = 1'b0;
        chk("csr_wstb", 128'(csr_wstb), 128'(4'b0010));
        chk("csr_q1", 128'(csr_q[1*DW +: DW]), 128'(32'hA5));
        gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("csr_wstb_once", 128'(csr_wstb), 128'(0));
        chk("csr_rd_rvalid", 128'(gb_rvalid), 128'(1));
        chk("csr_rd_din", 128'(gb_din), 128'(32'hA5));
        chk("csr_rd_err", 128'(gb_err), 128'(0));
        tick();
        chk("csr_rvalid_pulse", 128'(gb_rvalid), 128'(0));

        // Unused local offset reads 0 without error
        gb_addr = 24'h10; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("unused_rvalid", 128'(gb_rvalid), 128'(1));
        chk("unused_din", 128'(gb_din), 128'(0));
        chk("unused_err", 128'(gb_err), 128'(0));

        // RAM write and back-to-back local reads
        gb_addr = 24'h43; gb_dout = 32'h7; gb_we = 1'b1;
        tick();
        gb_we = 1'b0;
        gb_re = 1'b1;
        tick();
        chk("ram_rd_rvalid", 128'(gb_rvalid), 128'(1));
        chk("ram_rd_din", 128'(gb_din), 128'(32'h7));
        gb_addr = 24'h0;
        tick();
        gb_re = 1'b0;
        chk("b2b_rvalid", 128'(gb_rvalid), 128'(1));
        chk("b2b_din", 128'(gb_din), 128'(0));

        // Channel 0 write
        gb_addr = 24'h407; gb_dout = 32'hBEEF; gb_we = 1'b1;
        tick();
        gb_we = 1'b0;
        chk("ch0_we", 128'(sub_we), 128'(2'b01));
        chk("ch0_addr", 128'(sub_addr[0 +: AW]), 128'(24'h7));
        chk("ch0_dout", 128'(sub_dout), 128'(32'hBEEF));
        tick();
        chk("ch0_we_pulse", 128'(sub_we), 128'(0));

        // Channel 1 read, 5 busy cycles
        gb_addr = 24'h800; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("ch1_re", 128'(sub_re), 128'(2'b10));
        chk("ch1_addr", 128'(sub_addr[AW +: AW]), 128'(0));
        busy_cnt = gb_busy ? 1 : 0;
        gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("mid_wait_no_re", 128'(sub_re), 128'(0));
        busy_cnt += gb_busy ? 1 : 0;
        sub_rvalid = 2'b01;
        sub_din[0 +: DW] = 32'hDEAD;
        tick();
        sub_rvalid = 2'b00;
        chk("other_ch_ignored", 128'(gb_rvalid), 128'(0));
        busy_cnt += gb_busy ? 1 : 0;
        tick();
        busy_cnt += gb_busy ? 1 : 0;
        tick();
        busy_cnt += gb_busy ? 1 : 0;
        sub_rvalid = 2'b10;
        sub_din[DW +: DW] = 32'h1234;
        tick();
        sub_rvalid = 2'b00;
        chk("ch1_busy_cycles", 128'(busy_cnt), 128'(5));
        chk("ch1_rvalid", 128'(gb_rvalid), 128'(1));
        chk("ch1_din", 128'(gb_din), 128'(32'h1234));
        chk("ch1_busy_done", 128'(gb_busy), 128'(0));
        chk("ch1_err", 128'(gb_err), 128'(0));
        tick();
        chk("ch1_rvalid_pulse", 128'(gb_rvalid), 128'(0));
        chk("ch1_din_held", 128'(gb_din), 128'(32'h1234));

        // Unmapped region 3
        gb_addr = 24'hC00; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("unmap_rvalid", 128'(gb_rvalid), 128'(1));
        chk("unmap_err", 128'(gb_err), 128'(1));
        chk("unmap_din", 128'(gb_din), 128'(0));
        gb_dout = 32'hFFFF; gb_we = 1'b1;
        tick();
        gb_we = 1'b0;
        chk("unmap_wr_strb", 128'({sub_we, sub_re, csr_wstb, gb_rvalid, gb_err}), 128'(0));
        chk("unmap_wr_csr", 128'(csr_q), 128'({96'h0, 32'hA5, 32'h0} >> 0));

        // Simultaneous write and read: write only
        gb_addr = 24'h1; gb_dout = 32'h5A; gb_we = 1'b1; gb_re = 1'b1;
        tick();
        gb_we = 1'b0; gb_re = 1'b0;
        chk("wr_rd_no_rvalid", 128'(gb_rvalid), 128'(0));
        chk("wr_rd_csr1", 128'(csr_q[1*DW +: DW]), 128'(32'h5A));

`ifdef GHOSTBUS_TIMEOUT_EN
        gb_addr = 24'h400; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        wait_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (gb_rvalid) break;
            tick();
            wait_cnt++;
        end
        chk("tmo_cycles", 128'(wait_cnt), 128'(11));
        chk("tmo_din", 128'(gb_din), 128'(32'hFFFFFFFF));
        chk("tmo_err", 128'(gb_err), 128'(1));
        chk("tmo_busy", 128'(gb_busy), 128'(0));
`endif

        // Reset during WAIT
        gb_addr = 24'h800; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("rstw_busy", 128'(gb_busy), 128'(1));
        tick();
        gb_rst_n = 1'b0;
        #1;
        chk("rstw_busy_clr", 128'(gb_busy), 128'(0));
        chk("rstw_csr_q", 128'(csr_q), 128'(0));
        tick();
        gb_rst_n = 1'b1;
        sub_rvalid = 2'b10;
        tick();
        chk("rstw_late_rv", 128'(gb_rvalid), 128'(0));
        tick();
        sub_rvalid = 2'b00;
        chk("rstw_late_rv2", 128'(gb_rvalid), 128'(0));
        gb_addr = 24'h43; gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        chk("rstw_ram_kept", 128'(gb_din), 128'(32'h7));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
